// File: rtl/ceespu_int_ctrl.sv
// ---------------------------------------------------------------------------
// ceespu_int_ctrl
//   Interrupt controller in front of the decode stage. It latches
//   rising-edge requests from four sources, masks them, arbitrates, and
//   presents one request at a time to decode (O_int / O_int_vector). The
//   presented request is held stable until decode acknowledges it. After an
//   acknowledge, new requests are held off for HOLDOFF cycles and then
//   arbitration runs again.
//
//   Handshake: O_int stays high with O_int_vector frozen until I_int_ack is
//   sampled high in the same cycle. I_int_ack is a one-cycle pulse and is
//   ignored whenever O_int is low.
//
// Parameters
//   NUM_SRC  number of sources; must be 4 to match the 2-bit vector
//   HOLDOFF  cycles spent in HOLD after an ack (0..15)
//   RR_EN    1 = round-robin arbitration, 0 = fixed priority (source 0 wins)
//
// Ports
//   I_clk         clock; all state updates on the rising edge
//   I_rst_n       asynchronous active-low reset
//   I_irq         interrupt lines, rising-edge sensitive, synchronous
//   I_mask_we     mask register write strobe
//   I_mask_wdata  new mask value (1 = source enabled)
//   I_int_ack     acknowledge pulse from decode
//   O_int         interrupt request to decode
//   O_int_vector  index of the presented source
//   O_pending     pending latch contents, before masking
//   O_mask        current mask register
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module ceespu_int_ctrl #(
    parameter int NUM_SRC = 4,
    parameter int HOLDOFF = 2,
    parameter bit RR_EN   = 1'b1
) (
    input  logic               I_clk,
    input  logic               I_rst_n,
    input  logic [NUM_SRC-1:0] I_irq,
    input  logic               I_mask_we,
    input  logic [NUM_SRC-1:0] I_mask_wdata,
    input  logic               I_int_ack,
    output logic               O_int,
    output logic [1:0]         O_int_vector,
    output logic [NUM_SRC-1:0] O_pending,
    output logic [NUM_SRC-1:0] O_mask
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // State register is left visible by name (state_q) for hierarchical probes.
    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   irq_q;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0]   mask_q, mask_d;
    logic [1:0]           vec_q, vec_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [3:0]           cnt_q, cnt_d;

    logic [NUM_SRC-1:0]   irq_edge;
    logic [NUM_SRC-1:0]   cand;
    logic [NUM_SRC-1:0]   clr;
    logic                 win_valid;
    logic [1:0]           win_idx;
    logic [1:0]           rr_idx;

    // irq_q resets to 0, so a line already high at reset release is seen as
    // an edge on the first clock.
    assign irq_edge = I_irq & ~irq_q;
    assign cand     = pending_q & mask_q;

    // Arbitration. Both loops scan from the lowest-priority position down to
    // the highest so that the last hit (the highest-priority one) wins.
    always_comb begin
        win_valid = |cand;
        win_idx   = 2'd0;
        rr_idx    = 2'd0;
        if (RR_EN) begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                rr_idx = rr_ptr_q + 2'(i);
                if (cand[rr_idx]) begin
                    win_idx = rr_idx;
                end
            end
        end else begin
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    win_idx = 2'(i);
                end
            end
        end
    end

    // Next-state logic for the IDLE / REQ / HOLD sequencer.
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        clr      = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    vec_d   = win_idx;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // The presented request is never withdrawn or re-arbitrated;
                // only an ack moves the sequencer on.
                if (I_int_ack) begin
                    clr[vec_q] = 1'b1;
                    rr_ptr_d   = vec_q + 2'd1;
                    if (HOLDOFF == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = 4'(HOLDOFF);
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Leave HOLD on the cycle the counter is at 1, so the next
                // request rises HOLDOFF+1 edges after the ack.
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A new edge on the source being acknowledged keeps its pending bit set.
    assign pending_d = (pending_q & ~clr) | irq_edge;
    assign mask_d    = I_mask_we ? I_mask_wdata : mask_q;

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q   <= ST_IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            vec_q     <= 2'd0;
            rr_ptr_q  <= 2'd0;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            irq_q     <= I_irq;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            vec_q     <= vec_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign O_int        = (state_q == ST_REQ);
    assign O_int_vector = vec_q;
    assign O_pending    = pending_q;
    assign O_mask       = mask_q;

endmodule

// File: tb/tb_ceespu_int_ctrl.sv
`timescale 1ns/1ps
module tb_ceespu_int_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // round-robin instance (HOLDOFF=2)
  logic [3:0] irq = '0;
  logic       mask_we = 1'b0;
  logic [3:0] mask_wdata = '0;
  logic       ack = 1'b0;
  logic       o_int;
  logic [1:0] o_vec;
  logic [3:0] o_pend;
  logic [3:0] o_mask;

  // fixed-priority instance (HOLDOFF=2)
  logic [3:0] fp_irq = '0;
  logic       fp_ack = 1'b0;
  logic       fp_int;
  logic [1:0] fp_vec;
  logic [3:0] fp_pend;
  logic [3:0] fp_mask;

  ceespu_int_ctrl #(.NUM_SRC(4), .HOLDOFF(2), .RR_EN(1'b1)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_irq(irq), .I_mask_we(mask_we),
    .I_mask_wdata(mask_wdata), .I_int_ack(ack), .O_int(o_int),
    .O_int_vector(o_vec), .O_pending(o_pend), .O_mask(o_mask)
  );

  ceespu_int_ctrl #(.NUM_SRC(4), .HOLDOFF(2), .RR_EN(1'b0)) dut_fp (
    .I_clk(clk), .I_rst_n(rst_n), .I_irq(fp_irq), .I_mask_we(1'b0),
    .I_mask_wdata(4'h0), .I_int_ack(fp_ack), .O_int(fp_int),
    .O_int_vector(fp_vec), .O_pending(fp_pend), .O_mask(fp_mask)
  );

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_int(input bit use_fp, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if ((use_fp ? fp_int : o_int) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] irq;
    logic       we;
    logic [3:0] wd;
    logic       ack;
    logic       e_int;
    logic [1:0] e_vec;
    logic [3:0] e_pend;
    logic [3:0] e_mask;
  } row_t;

  row_t tbl[$];

  task automatic add(input logic [3:0] i_irq, input logic i_we, input logic [3:0] i_wd,
                     input logic i_ack, input logic e_int, input logic [1:0] e_vec,
                     input logic [3:0] e_pend, input logic [3:0] e_mask);
    row_t r;
    r.irq = i_irq; r.we = i_we; r.wd = i_wd; r.ack = i_ack;
    r.e_int = e_int; r.e_vec = e_vec; r.e_pend = e_pend; r.e_mask = e_mask;
    tbl.push_back(r);
  endtask

  int rises;
  logic prev_int;

  initial begin
    // ---- reset ----
    #12;
    check("reset_outputs", {o_int, o_vec, o_pend, o_mask}, {1'b0, 2'd0, 4'h0, 4'hF});
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table: single request, stall, ack/holdoff, masking ----
    //   irq     we   wd    ack   int  vec  pend     mask
    add(4'b0100, 0, 4'h0, 0,    0,   2'd0, 4'b0100, 4'hF); // pending after edge 1
    add(4'b0000, 0, 4'h0, 0,    1,   2'd2, 4'b0100, 4'hF); // request after edge 2
    for (int i = 0; i < 2; i++)
      add(4'b0000, 0, 4'h0, 0,  1,   2'd2, 4'b0100, 4'hF); // stalled
    add(4'b0001, 0, 4'h0, 0,    1,   2'd2, 4'b0101, 4'hF); // higher prio arrives
    for (int i = 0; i < 7; i++)
      add(4'b0000, 0, 4'h0, 0,  1,   2'd2, 4'b0101, 4'hF); // still frozen
    add(4'b0000, 0, 4'h0, 1,    0,   2'd2, 4'b0001, 4'hF); // ack
    add(4'b0000, 0, 4'h0, 0,    0,   2'd2, 4'b0001, 4'hF); // hold
    add(4'b0000, 0, 4'h0, 0,    0,   2'd2, 4'b0001, 4'hF); // hold -> idle
    add(4'b0000, 0, 4'h0, 0,    1,   2'd0, 4'b0001, 4'hF); // next request
    add(4'b0000, 0, 4'h0, 1,    0,   2'd0, 4'b0000, 4'hF); // ack
    add(4'b0000, 0, 4'h0, 0,    0,   2'd0, 4'b0000, 4'hF);
    add(4'b0000, 0, 4'h0, 0,    0,   2'd0, 4'b0000, 4'hF);
    add(4'b0000, 1, 4'hE, 0,    0,   2'd0, 4'b0000, 4'hE); // mask out source 0
    add(4'b0001, 0, 4'h0, 0,    0,   2'd0, 4'b0001, 4'hE); // latched, not raised
    add(4'b0000, 0, 4'h0, 0,    0,   2'd0, 4'b0001, 4'hE);
    add(4'b0000, 0, 4'h0, 0,    0,   2'd0, 4'b0001, 4'hE);
    add(4'b0000, 1, 4'hF, 0,    0,   2'd0, 4'b0001, 4'hF); // unmask
    add(4'b0000, 0, 4'h0, 0,    1,   2'd0, 4'b0001, 4'hF); // raised 2 edges after write
    add(4'b0000, 0, 4'h0, 1,    0,   2'd0, 4'b0000, 4'hF);
    add(4'b0000, 0, 4'h0, 0,    0,   2'd0, 4'b0000, 4'hF);
    add(4'b0000, 0, 4'h0, 0,    0,   2'd0, 4'b0000, 4'hF);

    foreach (tbl[i]) begin
      irq = tbl[i].irq; mask_we = tbl[i].we; mask_wdata = tbl[i].wd; ack = tbl[i].ack;
      step();
      check($sformatf("row%0d", i), {o_int, o_vec, o_pend, o_mask},
            {tbl[i].e_int, tbl[i].e_vec, tbl[i].e_pend, tbl[i].e_mask});
    end
    irq = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0;
    step();

    // ---- async reset in the middle of a request ----
    irq = 4'b0100; step();
    irq = 4'b0000; step();
    irq = 4'b1000; step();
    irq = 4'b0000;
    check("pre_reset_req", {o_int, o_vec, o_pend}, {1'b1, 2'd2, 4'b1100});
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {o_int, o_vec, o_pend, o_mask}, {1'b0, 2'd0, 4'h0, 4'hF});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---- round robin: all four at once, served 0,1,2,3 ----
    irq = 4'b1111; step();
    irq = 4'b0000;
    check("rr_pending_all", 32'(o_pend), 32'h0000000F);
    for (int i = 0; i < 4; i++) begin
      wait_int(1'b0, 20, $sformatf("rr_wait%0d", i));
      check($sformatf("rr_vec%0d", i), 32'(o_vec), 32'(i));
      ack = 1'b1; step(); ack = 1'b0;
      check($sformatf("rr_drop%0d", i), 32'(o_int), 32'd0);
    end
    check("rr_pending_empty", 32'(o_pend), 32'd0);
    for (int i = 0; i < 4; i++) step();

    // ---- level-held line gives one pending bit and one request ----
    irq = 4'b1000;
    rises = 0;
    prev_int = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_int && !prev_int) rises++;
      prev_int = o_int;
    end
    check("held_one_request", 32'(rises), 32'd1);
    check("held_state", {o_int, o_vec, o_pend}, {1'b1, 2'd3, 4'b1000});
    irq = 4'b0000; step();
    // new edge on source 3 together with its ack: stays pending
    irq = 4'b1000; ack = 1'b1; step();
    irq = 4'b0000; ack = 1'b0;
    check("set_wins_over_clear", {o_int, o_pend}, {1'b0, 4'b1000});
    step();
    check("holdoff_1", 32'(o_int), 32'd0);
    step();
    check("holdoff_2", 32'(o_int), 32'd0);
    step();
    check("rerequest", {o_int, o_vec}, {1'b1, 2'd3});
    ack = 1'b1; step(); ack = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("idle_clean", {o_int, o_pend}, {1'b0, 4'b0000});

    // ---- spurious ack while idle ----
    ack = 1'b1; step(); ack = 1'b0;
    check("spurious_ack", {o_int, o_vec, o_pend}, {1'b0, 2'd3, 4'b0000});
    irq = 4'b0010; step(); irq = 4'b0000;
    check("after_spurious_pend", {o_int, o_pend}, {1'b0, 4'b0010});
    step();
    check("after_spurious_req", {o_int, o_vec}, {1'b1, 2'd1});
    ack = 1'b1; step(); ack = 1'b0;

    // ---- fixed priority: sources 1 and 3, always vector 1 ----
    for (int r = 0; r < 3; r++) begin
      fp_irq = 4'b1010; step(); fp_irq = 4'b0000;
      wait_int(1'b1, 20, $sformatf("fp_wait%0d", r));
      check($sformatf("fp_vec%0d", r), 32'(fp_vec), 32'd1);
      fp_ack = 1'b1; step(); fp_ack = 1'b0;
    end
    check("fp_pending_left", {fp_int, fp_pend, fp_mask}, {1'b0, 4'b1000, 4'hF});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
